instr_fetch: RTL and testbench

Instruction fetch stage for the single-cycle/pipelined RV32I core. Holds the architectural fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions, tagged with their PC, in a 2-entry FIFO for decode. Redirects from branch resolution (PC + ImmOp targets) flush buffered and in-flight fetches. Sequential PC + 4 stepping is done locally.

---
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage. Owns the fetch PC, issues word reads over a
// req/gnt/rvalid handshake, and queues returned words with their PCs in a
// 2-entry FIFO for decode. Redirects flush queued and in-flight fetches.
module instr_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  // Architectural fetch PC
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  // PCs of granted, not-yet-answered, non-stale reads (in issue order)
  logic [WIDTH-1:0] pend_pc_q [2];
  logic             pend_head_q, pend_head_d;
  logic [1:0]       pend_cnt_q, pend_cnt_d;

  // All granted, unanswered reads, and how many of those are stale
  logic [1:0]       inflight_q, inflight_d;
  logic [1:0]       drop_q, drop_d;

  // Output FIFO of {pc, instr}
  logic [WIDTH-1:0] fifo_pc_q [2];
  logic [WIDTH-1:0] fifo_instr_q [2];
  logic             fifo_head_q, fifo_head_d;
  logic [1:0]       count_q, count_d;

  logic             pop;
  logic             issue;
  logic             resp_dec;
  logic             deliver;
  logic             push;
  logic             pend_push;
  logic             pend_tail;
  logic             fifo_tail;
  logic [2:0]       credit_used;

  // Low address bits of the target are architecturally ignored
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake decode and output drive
  always_comb begin
    pop         = (count_q != 2'd0) && instr_ready;
    // Every in-flight read needs a FIFO slot reserved for its answer
    credit_used = {1'b0, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    imem_req    = rst_n && !redirect && (credit_used < 3'd2);
    imem_addr   = fetch_pc_q;
    issue       = imem_req && imem_gnt;
    resp_dec    = imem_rvalid && (inflight_q != 2'd0);
    deliver     = imem_rvalid && !redirect && (drop_q == 2'd0) && (pend_cnt_q != 2'd0);
    push        = deliver && ((count_q != 2'd2) || pop);
    pend_push   = issue && (pend_cnt_q != 2'd2);
    // With two slots, tail is head when empty or full, the other slot otherwise
    pend_tail   = pend_head_q ^ pend_cnt_q[0];
    fifo_tail   = fifo_head_q ^ count_q[0];
    instr_valid = (count_q != 2'd0);
    instr       = fifo_instr_q[fifo_head_q];
    instr_pc    = fifo_pc_q[fifo_head_q];
  end

  // Next-state for PC, counters and queue pointers; redirect overrides everything
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pend_head_d = pend_head_q;
    pend_cnt_d  = pend_cnt_q;
    inflight_d  = inflight_q;
    drop_d      = drop_q;
    fifo_head_d = fifo_head_q;
    count_d     = count_q;
    if (redirect) begin
      fetch_pc_d  = {redirect_pc[WIDTH-1:2], 2'b00};
      pend_head_d = 1'b0;
      pend_cnt_d  = 2'd0;
      fifo_head_d = 1'b0;
      count_d     = 2'd0;
      // Everything still outstanding after this cycle's answer is stale
      inflight_d  = inflight_q - {1'b0, resp_dec};
      drop_d      = inflight_q - {1'b0, resp_dec};
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + WIDTH'(4);
      end
      inflight_d = inflight_q + {1'b0, issue} - {1'b0, resp_dec};
      if (imem_rvalid && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
      pend_cnt_d = pend_cnt_q + {1'b0, pend_push} - {1'b0, deliver};
      if (deliver) begin
        pend_head_d = ~pend_head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        fifo_head_d = ~fifo_head_q;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      pend_head_q <= 1'b0;
      pend_cnt_q  <= 2'd0;
      inflight_q  <= 2'd0;
      drop_q      <= 2'd0;
      fifo_head_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_head_q <= pend_head_d;
      pend_cnt_q  <= pend_cnt_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      fifo_head_q <= fifo_head_d;
      count_q     <= count_d;
    end
  end

  // Pending-PC storage: record the address of each issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_pc_q[0] <= '0;
      pend_pc_q[1] <= '0;
    end else if (pend_push) begin
      pend_pc_q[pend_tail] <= fetch_pc_q;
    end
  end

  // FIFO storage: tag each accepted response with its issue PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_pc_q[0]    <= '0;
      fifo_pc_q[1]    <= '0;
      fifo_instr_q[0] <= '0;
      fifo_instr_q[1] <= '0;
    end else if (push) begin
      fifo_pc_q[fifo_tail]    <= pend_pc_q[pend_head_q];
      fifo_instr_q[fifo_tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed per-cycle table on a RESET_PC=0xFFFF_FFF8
// instance, then queue-based reference model with randomized memory,
// backpressure and redirects on the default instance.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        redirect, redirect2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_gnt, imem_gnt2;
  logic        imem_rvalid, imem_rvalid2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        instr_valid, instr_valid2;
  logic        instr_ready, instr_ready2;
  logic [31:0] instr, instr2;
  logic [31:0] instr_pc, instr_pc2;

  instr_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .instr(instr2), .instr_pc(instr_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
  endfunction

  // Directed table record for the second instance
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vt [11];

  // Reference model: outstanding reads (memory side) and expected FIFO contents
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } out_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  out_t        oq[$];
  ent_t        fq[$];
  logic [31:0] fpc;
  int          cyc;
  int          k_lo, k_hi, gnt_pct, ready_pct, redir_permil;
  bit          force_redir, redir_on_rvpop, watch;
  logic [31:0] force_target, first_pc;
  int          first_valid_cyc;

  task automatic model_reset();
    oq.delete();
    fq.delete();
    fpc = 32'h0;
    cyc = 1;
  endtask

  // One clock of the default instance: drive, check against model, advance model
  task automatic run_cycle();
    logic rv, pop_m, exp_req, rd, hit;
    out_t e;
    int   k;
    rv          = (oq.size() > 0) && (oq[0].due <= cyc);
    instr_ready = int'($urandom_range(99)) < ready_pct;
    imem_gnt    = int'($urandom_range(99)) < gnt_pct;
    hit         = redir_on_rvpop && rv && (fq.size() > 0) && instr_ready;
    rd          = force_redir || hit || (int'($urandom_range(999)) < redir_permil);
    if (hit) redir_on_rvpop = 1'b0;
    redirect    = rd;
    redirect_pc = (force_redir || hit) ? force_target : $urandom();
    force_redir = 1'b0;
    imem_rvalid = rv;
    if (rv) imem_rdata = mem_data(oq[0].addr);
    else    imem_rdata = $urandom();
    #4;
    pop_m   = (fq.size() > 0) && instr_ready;
    exp_req = !rd && ((oq.size() + fq.size() - (pop_m ? 1 : 0)) < 2);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, fpc);
    chk("instr_valid", instr_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("instr_pc", instr_pc, fq[0].pc);
      chk("instr", instr, fq[0].ins);
    end
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop_m && !rd && watch) begin
      first_pc = instr_pc;
      watch    = 1'b0;
    end
    if (rd) begin
      foreach (oq[i]) oq[i].stale = 1'b1;
      if (rv) void'(oq.pop_front());
      fq.delete();
      fpc   = {redirect_pc[31:2], 2'b00};
      watch = 1'b1;
    end else begin
      if (pop_m) void'(fq.pop_front());
      if (rv) begin
        e = oq.pop_front();
        if (!e.stale) fq.push_back('{pc: e.addr, ins: mem_data(e.addr)});
      end
      if (exp_req && imem_gnt) begin
        k = int'($urandom_range(k_hi, k_lo));
        oq.push_back('{addr: fpc, due: cyc + k, stale: 1'b0});
        fpc = fpc + 32'd4;
      end
      if (fq.size() > 2) begin
        checks++;
        errors++;
        $display("FAIL fifo_overflow: model holds %0d entries, at most 2 allowed", fq.size());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Run until the model has two reads outstanding; expiry counts as a failure
  task automatic wait_two_inflight(input string name);
    int n;
    n = 0;
    while (oq.size() != 2 && n < 20) begin
      run_cycle();
      n++;
    end
    chk(name, oq.size(), 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b1;
    redirect2 = 1'b0; redirect_pc2 = '0; imem_gnt2 = 1'b0; imem_rvalid2 = 1'b0;
    imem_rdata2 = '0; instr_ready2 = 1'b1;
    k_lo = 1; k_hi = 1; gnt_pct = 100; ready_pct = 100; redir_permil = 0;
    force_redir = 1'b0; redir_on_rvpop = 1'b0; watch = 1'b0;
    force_target = '0; first_pc = '0; first_valid_cyc = -1;
    model_reset();

    // Directed per-cycle table for RESET_PC = 0xFFFF_FFF8, k = 1
    vt[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1,
               1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, mem_data(32'hFFFF_FFF8), 1'b1,
               1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, mem_data(32'hFFFF_FFFC), 1'b0,
               1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
    vt[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0,
               1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
    vt[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1,
               1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
    vt[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, mem_data(32'h0), 1'b1,
               1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
    vt[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, mem_data(32'h4), 1'b1,
               1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
    vt[7]  = '{1'b1, 32'h102, 1'b1, 1'b0, 32'h0, 1'b1,
               1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vt[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1,
               1'b1, 32'h0000_0100, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h0,   1'b0, 1'b1, mem_data(32'h100), 1'b1,
               1'b1, 32'h0000_0104, 1'b0, 32'h0};
    vt[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b0,
               1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};

    @(posedge clk);
    #1;
    // Reset values of both instances
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst2_req", imem_req2, 1'b0);
    chk("rst2_addr", imem_addr2, 32'hFFFF_FFF8);
    chk("rst2_valid", instr_valid2, 1'b0);

    // Table run on the second instance, covering the address wrap
    rst2_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      redirect2    = vt[i].redir;
      redirect_pc2 = vt[i].rpc;
      imem_gnt2    = vt[i].gnt;
      imem_rvalid2 = vt[i].rv;
      imem_rdata2  = vt[i].rd;
      instr_ready2 = vt[i].rdy;
      #4;
      chk($sformatf("t2_req[%0d]", i), imem_req2, vt[i].e_req);
      chk($sformatf("t2_addr[%0d]", i), imem_addr2, vt[i].e_addr);
      chk($sformatf("t2_valid[%0d]", i), instr_valid2, vt[i].e_valid);
      if (vt[i].e_valid) begin
        chk($sformatf("t2_pc[%0d]", i), instr_pc2, vt[i].e_pc);
        chk($sformatf("t2_instr[%0d]", i), instr2, mem_data(vt[i].e_pc));
      end
      @(posedge clk);
      #1;
    end
    // Asynchronous reset mid-stream on the second instance
    chk("t2_pre_rst_valid", instr_valid2, 1'b1);
    rst2_n = 1'b0;
    #1;
    chk("t2_async_valid", instr_valid2, 1'b0);
    chk("t2_async_pc", instr_pc2, 32'h0);
    chk("t2_async_req", imem_req2, 1'b0);
    chk("t2_async_addr", imem_addr2, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;

    // Release of the default instance, k = 1, always ready
    rst_n = 1'b1;
    model_reset();
    run_n(30);
    chk("first_valid_cycle", first_valid_cyc, 3);

    // Backpressure for 10 cycles, then resume
    ready_pct = 0;
    run_n(10);
    chk("bp_req_low", imem_req, 1'b0);
    chk("bp_valid_held", instr_valid, 1'b1);
    ready_pct = 100;
    run_n(10);

    // Redirect to 0x102 with two reads in flight, k = 3
    k_lo = 3; k_hi = 3;
    wait_two_inflight("p3_setup");
    force_target = 32'h0000_0102; force_redir = 1'b1; first_pc = 32'hDEAD_BEEF;
    run_n(25);
    chk("p3_first_pc", first_pc, 32'h100);

    // Redirect coinciding with a response and a pop, k = 2
    k_lo = 2; k_hi = 2;
    run_n(6);
    force_target = 32'h0000_0200; redir_on_rvpop = 1'b1; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 30 && redir_on_rvpop; i++) run_cycle();
    chk("p4_setup", redir_on_rvpop, 1'b0);
    run_n(20);
    chk("p4_first_pc", first_pc, 32'h200);

    // Back-to-back redirects while stale reads drain, k = 3
    k_lo = 3; k_hi = 3;
    wait_two_inflight("p5_setup");
    force_target = 32'h0000_0040; force_redir = 1'b1; first_pc = 32'hDEAD_BEEF;
    run_cycle();
    force_target = 32'h0000_0080; force_redir = 1'b1;
    run_n(30);
    chk("p5_first_pc", first_pc, 32'h80);

    // Randomized grants, latency, backpressure and redirects
    k_lo = 1; k_hi = 4; gnt_pct = 70; ready_pct = 70; redir_permil = 30;
    run_n(1500);

    // Asynchronous reset mid-stream on the default instance
    k_lo = 1; k_hi = 1; gnt_pct = 100; ready_pct = 0; redir_permil = 0;
    run_n(5);
    chk("pre_rst_valid", instr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 1'b0);
    chk("async_req", imem_req, 1'b0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_instr_pc", instr_pc, 32'h0);
    chk("async_instr", instr, 32'h0);
    imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    ready_pct = 100;
    run_n(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
